// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - MIPS32 ID/EX pipeline register with load-use hazard detection and WB bypass
//
// Captures decoded operands and control from ID each cycle. Inserts a bubble on
// flush or load-use hazard, holds everything under ext_stall, and substitutes
// write-back data for register-file reads of a register being written this cycle.
//
// Optional feature macro: ID_EX_STATS_EN (bubble counters load_use_bubbles,
// flush_bubbles; absent when undefined).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_*                            decoded instruction fields, operands, control
//   mem_wb_*                        write-back port used for the ID bypass
//   flush                           discard the ID instruction
//   ext_stall                       hold all registers
//   stall_if_id                     combinational request to hold PC and IF/ID
//   id_ex_*                         registered EX-stage operands and control
//   load_use_bubbles, flush_bubbles saturating bubble counters (ID_EX_STATS_EN)

module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_pc_plus4,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        id_alu_src,
    input  logic        id_reg_dst,
    input  logic [3:0]  id_alu_op,
    input  logic        mem_wb_reg_write,
    input  logic [4:0]  mem_wb_write_reg_addr,
    input  logic [31:0] mem_wb_write_data,
    input  logic        flush,
    input  logic        ext_stall,
    output logic        stall_if_id,
    output logic        id_ex_valid,
    output logic [4:0]  id_ex_instr_rs,
    output logic [4:0]  id_ex_instr_rt,
    output logic [4:0]  id_ex_write_reg_addr,
    output logic [31:0] id_ex_rs_data,
    output logic [31:0] id_ex_rt_data,
    output logic [31:0] id_ex_imm,
    output logic [31:0] id_ex_pc_plus4,
    output logic        id_ex_reg_write,
    output logic        id_ex_mem_read,
    output logic        id_ex_mem_write,
    output logic        id_ex_mem_to_reg,
    output logic        id_ex_alu_src,
    output logic [3:0]  id_ex_alu_op
`ifdef ID_EX_STATS_EN
    ,
    output logic [15:0] load_use_bubbles,
    output logic [15:0] flush_bubbles
`endif
);

    logic hazard;
    logic wb_hits_rs;
    logic wb_hits_rt;

    // A load in EX whose destination is read by the ID instruction cannot be
    // forwarded in time; $0 never counts since it is hard-wired to zero.
    always_comb begin
        hazard = id_ex_valid && id_ex_mem_read && (id_ex_write_reg_addr != 5'd0) &&
                 ((id_uses_rs && (id_rs_addr == id_ex_write_reg_addr)) ||
                  (id_uses_rt && (id_rt_addr == id_ex_write_reg_addr)));
    end

    // A flushed instruction is discarded anyway, so it must not stall IF/ID.
    assign stall_if_id = hazard && !flush;

    // Register file is read in the same cycle WB writes it; take WB data instead.
    assign wb_hits_rs = mem_wb_reg_write && (mem_wb_write_reg_addr != 5'd0) &&
                        (mem_wb_write_reg_addr == id_rs_addr);
    assign wb_hits_rt = mem_wb_reg_write && (mem_wb_write_reg_addr != 5'd0) &&
                        (mem_wb_write_reg_addr == id_rt_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_valid          <= 1'b0;
            id_ex_instr_rs       <= 5'd0;
            id_ex_instr_rt       <= 5'd0;
            id_ex_write_reg_addr <= 5'd0;
            id_ex_rs_data        <= 32'd0;
            id_ex_rt_data        <= 32'd0;
            id_ex_imm            <= 32'd0;
            id_ex_pc_plus4       <= 32'd0;
            id_ex_reg_write      <= 1'b0;
            id_ex_mem_read       <= 1'b0;
            id_ex_mem_write      <= 1'b0;
            id_ex_mem_to_reg     <= 1'b0;
            id_ex_alu_src        <= 1'b0;
            id_ex_alu_op         <= 4'd0;
        end else if (ext_stall) begin
            // hold: all registers keep their value
        end else if (flush || hazard) begin
            // Zeroed addresses keep the EX forwarding unit from matching a bubble.
            id_ex_valid          <= 1'b0;
            id_ex_instr_rs       <= 5'd0;
            id_ex_instr_rt       <= 5'd0;
            id_ex_write_reg_addr <= 5'd0;
            id_ex_rs_data        <= 32'd0;
            id_ex_rt_data        <= 32'd0;
            id_ex_imm            <= 32'd0;
            id_ex_pc_plus4       <= 32'd0;
            id_ex_reg_write      <= 1'b0;
            id_ex_mem_read       <= 1'b0;
            id_ex_mem_write      <= 1'b0;
            id_ex_mem_to_reg     <= 1'b0;
            id_ex_alu_src        <= 1'b0;
            id_ex_alu_op         <= 4'd0;
        end else begin
            id_ex_valid          <= 1'b1;
            id_ex_instr_rs       <= id_rs_addr;
            id_ex_instr_rt       <= id_rt_addr;
            id_ex_write_reg_addr <= id_reg_dst ? id_rd_addr : id_rt_addr;
            id_ex_rs_data        <= wb_hits_rs ? mem_wb_write_data : id_rs_data;
            id_ex_rt_data        <= wb_hits_rt ? mem_wb_write_data : id_rt_data;
            id_ex_imm            <= id_imm;
            id_ex_pc_plus4       <= id_pc_plus4;
            id_ex_reg_write      <= id_reg_write;
            id_ex_mem_read       <= id_mem_read;
            id_ex_mem_write      <= id_mem_write;
            id_ex_mem_to_reg     <= id_mem_to_reg;
            id_ex_alu_src        <= id_alu_src;
            id_ex_alu_op         <= id_alu_op;
        end
    end

`ifdef ID_EX_STATS_EN
    // Flush takes precedence, so a flush coinciding with a hazard counts as flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_use_bubbles <= 16'd0;
            flush_bubbles    <= 16'd0;
        end else if (!ext_stall) begin
            if (flush) begin
                if (flush_bubbles != 16'hFFFF)
                    flush_bubbles <= flush_bubbles + 16'd1;
            end else if (hazard) begin
                if (load_use_bubbles != 16'hFFFF)
                    load_use_bubbles <= load_use_bubbles + 16'd1;
            end
        end
    end
`endif

endmodule
